csrng_state_wb: RTL and testbench
=================================

// Module: csrng_state_wb
// PURPOSE
// - Downstream of the ctr_drbg command stage: takes its final key/V/reseed-count/fips result per instance.
// - Checks command legality against per-instance state and writes the state database (NumApps entries).
// - Returns one ack+status per command.
// - Provides a combinational read port that supplies key/V/rc/fips to the command stage input.
// PARAMETERS
// - NumApps  3    number of state entries (instance ids 0..NumApps-1)
// - Cmd      3    command code width (csrng_pkg codes INS/RES/GEN/UPD/UNI)
// - StateId  4    instance id width
// - BlkLen   128  V width
// - KeyLen   256  key width
// - CtrLen   32   reseed counter width
// PORTS
// clk_i              in   1        clock
// rst_i              in   1        asynchronous active-high reset
// enable_i           in   1        block enable; low = synchronous clear of FSM and database
// wb_req_i           in   1        write-back valid from command stage
// wb_rdy_o           out  1        ready; transfer on wb_req_i && wb_rdy_o
// wb_ccmd_i          in   Cmd      command code
// wb_inst_id_i       in   StateId  instance id
// wb_glast_i         in   1        last GEN beat
// wb_key_i           in   KeyLen   new key
// wb_v_i             in   BlkLen   new V
// wb_rc_i            in   CtrLen   new reseed count
// wb_fips_i          in   1        new fips flag
// reseed_interval_i  in   CtrLen   max GEN count before reseed is required
// ack_o              out  1        response valid
// ack_rdy_i          in   1        response consumed; transfer on ack_o && ack_rdy_i
// ack_sts_o          out  csrng_cmd_sts_e  response status
// ack_inst_id_o      out  StateId  instance id of response
// rd_inst_id_i       in   StateId  read address
// rd_valid_o         out  1        entry instantiated (0 if address out of range)
// rd_key_o           out  KeyLen   entry key (0 if out of range)
// rd_v_o             out  BlkLen   entry V
// rd_rc_o            out  CtrLen   entry reseed count
// rd_fips_o          out  1        entry fips flag
// BEHAVIOUR
// - Reset / enable_i low:
//   - FSM to IDLE; all entries valid=0, key/V/rc/fips=0.
//   - Outputs: wb_rdy_o=1 (0 while enable_i low), ack_o=0, ack_sts_o=CMD_STS_SUCCESS, ack_inst_id_o=0.
//   - Clear takes priority over any in-flight write/ack; the pending ack is dropped.
// - FSM IDLE -> WB -> RSP -> IDLE:
//   - IDLE: wb_rdy_o=1. On transfer, register all wb_* inputs and go to WB.
//   - WB (1 cycle, wb_rdy_o=0): evaluate the checks below in order, apply the write at the end-of-cycle edge, register the status, go to RSP.
//   - WB exception: GEN with glast=0 and status SUCCESS goes straight to IDLE with no ack; its write is still applied.
//   - RSP: ack_o=1 with status held stable until ack_rdy_i; then go to IDLE. No new command is accepted until return to IDLE.
// - Latency: transfer at edge N -> database updated and ack_o=1 in cycle N+2; next wb_rdy_o=1 the cycle after the ack transfer.
// - Checks (first match wins; on any error there is no database write):
//   1. inst_id >= NumApps -> CMD_STS_INVALID_ACMD
//   2. INS on a valid entry, or RES/GEN/UPD/UNI on an invalid entry -> CMD_STS_INVALID_CMD_SEQ
//   3. GEN with rc > reseed_interval_i -> CMD_STS_RESEED_CNT_EXCEEDED
//   4. otherwise -> CMD_STS_SUCCESS
// - Writes:
//   - INS/RES/GEN/UPD: key/V/rc/fips <= inputs; valid <= 1.
//   - UNI: entry zeroed; valid <= 0.
//   - Unknown ccmd -> CMD_STS_INVALID_ACMD, no write.
// - Read port: purely combinational from the database registers; a write from WB is visible in the next cycle.
// - rc comparison is unsigned over the full CtrLen; no wrap handling (rc supplied by upstream).
// TESTING
// - Reset, INS id0 key=K1 rc=0 -> ack cycle N+2, SUCCESS, rd id0 valid=1 key=K1.
// - INS id0 twice -> second ack CMD_STS_INVALID_CMD_SEQ; key unchanged.
// - GEN id0 three beats glast=0,0,1 -> exactly one ack (SUCCESS); rd_v_o = last beat's V.
// - reseed_interval_i=4, GEN id0 rc=5 -> CMD_STS_RESEED_CNT_EXCEEDED; rc unchanged.
// - inst_id=7 (NumApps=3) -> CMD_STS_INVALID_ACMD; rd_inst_id_i=7 -> all rd_* 0.
// - ack_rdy_i held 0 for 5 cycles while wb_req_i=1 -> ack stable, wb_rdy_o=0; enable_i low mid-RSP -> ack_o=0 next cycle, id0 valid=0.

Source files
------------

// File: rtl/csrng_state_wb.sv
// csrng_state_wb: write-back stage of the ctr_drbg pipeline.
// Takes the final key/V/reseed-count/fips result for each command. It checks
// whether the command is legal for the instance's current state and, if it is,
// writes the per-instance state database (NumApps entries). It returns one
// ack with a status per command, except for non-final GEN beats that succeed.
// It also provides a combinational read port into the database.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            block enable; low synchronously clears the FSM and the database
//   wb_req_i/wb_rdy_o   write-back handshake; the wb_* payload is captured on transfer
//   reseed_interval_i   maximum reseed count that GEN accepts
//   ack_o/ack_rdy_i     response handshake, with ack_sts_o and ack_inst_id_o
//   rd_inst_id_i        read address; rd_* return that entry, or zeros if out of range

package csrng_pkg;
  typedef enum logic [2:0] {
    INS = 3'd1,
    RES = 3'd2,
    GEN = 3'd3,
    UPD = 3'd4,
    UNI = 3'd5
  } acmd_e;

  typedef enum logic [2:0] {
    CMD_STS_SUCCESS             = 3'd0,
    CMD_STS_INVALID_ACMD        = 3'd1,
    CMD_STS_INVALID_GEN_CMD     = 3'd2,
    CMD_STS_INVALID_CMD_SEQ     = 3'd3,
    CMD_STS_RESEED_CNT_EXCEEDED = 3'd4
  } csrng_cmd_sts_e;
endpackage

module csrng_state_wb
  import csrng_pkg::*;
#(
  parameter int unsigned NumApps = 3,
  parameter int unsigned Cmd     = 3,
  parameter int unsigned StateId = 4,
  parameter int unsigned BlkLen  = 128,
  parameter int unsigned KeyLen  = 256,
  parameter int unsigned CtrLen  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               wb_req_i,
  output logic               wb_rdy_o,
  input  logic [Cmd-1:0]     wb_ccmd_i,
  input  logic [StateId-1:0] wb_inst_id_i,
  input  logic               wb_glast_i,
  input  logic [KeyLen-1:0]  wb_key_i,
  input  logic [BlkLen-1:0]  wb_v_i,
  input  logic [CtrLen-1:0]  wb_rc_i,
  input  logic               wb_fips_i,
  input  logic [CtrLen-1:0]  reseed_interval_i,
  output logic               ack_o,
  input  logic               ack_rdy_i,
  output csrng_cmd_sts_e     ack_sts_o,
  output logic [StateId-1:0] ack_inst_id_o,
  input  logic [StateId-1:0] rd_inst_id_i,
  output logic               rd_valid_o,
  output logic [KeyLen-1:0]  rd_key_o,
  output logic [BlkLen-1:0]  rd_v_o,
  output logic [CtrLen-1:0]  rd_rc_o,
  output logic               rd_fips_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_RSP} state_e;

  state_e state_q, state_d;

  // Captured command
  logic [Cmd-1:0]     ccmd_q;
  logic [StateId-1:0] id_q;
  logic               glast_q;
  logic [KeyLen-1:0]  key_in_q;
  logic [BlkLen-1:0]  v_in_q;
  logic [CtrLen-1:0]  rc_in_q;
  logic               fips_in_q;
  csrng_cmd_sts_e     sts_q;

  // State database
  logic               valid_q [NumApps];
  logic [KeyLen-1:0]  key_q   [NumApps];
  logic [BlkLen-1:0]  v_q     [NumApps];
  logic [CtrLen-1:0]  rc_q    [NumApps];
  logic               fips_q  [NumApps];

  logic           id_ok, ent_valid, cmd_known, is_ins, is_gen, is_uni, we;
  csrng_cmd_sts_e sts_d;

  assign wb_rdy_o      = enable_i && (state_q == ST_IDLE);
  assign ack_o         = (state_q == ST_RSP);
  assign ack_sts_o     = sts_q;
  assign ack_inst_id_o = id_q;

  assign is_ins    = (ccmd_q == Cmd'(INS));
  assign is_gen    = (ccmd_q == Cmd'(GEN));
  assign is_uni    = (ccmd_q == Cmd'(UNI));
  assign cmd_known = is_ins || is_gen || is_uni ||
                     (ccmd_q == Cmd'(RES)) || (ccmd_q == Cmd'(UPD));

  always_comb begin
    id_ok     = 1'b0;
    ent_valid = 1'b0;
    for (int unsigned i = 0; i < NumApps; i++) begin
      if (id_q == StateId'(i)) begin
        id_ok     = 1'b1;
        ent_valid = valid_q[i];
      end
    end
  end

  // Legality checks, first match wins; a write happens only on success
  always_comb begin
    sts_d = CMD_STS_SUCCESS;
    we    = 1'b0;
    if (!id_ok || !cmd_known) begin
      sts_d = CMD_STS_INVALID_ACMD;
    end else if (is_ins == ent_valid) begin
      sts_d = CMD_STS_INVALID_CMD_SEQ;
    end else if (is_gen && (rc_in_q > reseed_interval_i)) begin
      sts_d = CMD_STS_RESEED_CNT_EXCEEDED;
    end else begin
      we = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (wb_req_i && wb_rdy_o) state_d = ST_WB;
      // Intermediate GEN beats that succeed are not acknowledged
      ST_WB:   state_d = (is_gen && !glast_q && we) ? ST_IDLE : ST_RSP;
      ST_RSP:  if (ack_rdy_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_valid_o = 1'b0;
    rd_key_o   = '0;
    rd_v_o     = '0;
    rd_rc_o    = '0;
    rd_fips_o  = 1'b0;
    for (int unsigned i = 0; i < NumApps; i++) begin
      if (rd_inst_id_i == StateId'(i)) begin
        rd_valid_o = valid_q[i];
        rd_key_o   = key_q[i];
        rd_v_o     = v_q[i];
        rd_rc_o    = rc_q[i];
        rd_fips_o  = fips_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ccmd_q    <= '0;
      id_q      <= '0;
      glast_q   <= 1'b0;
      key_in_q  <= '0;
      v_in_q    <= '0;
      rc_in_q   <= '0;
      fips_in_q <= 1'b0;
      sts_q     <= CMD_STS_SUCCESS;
      for (int unsigned i = 0; i < NumApps; i++) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        v_q[i]     <= '0;
        rc_q[i]    <= '0;
        fips_q[i]  <= 1'b0;
      end
    end else if (!enable_i) begin
      // The disable clear also drops any pending ack
      state_q   <= ST_IDLE;
      ccmd_q    <= '0;
      id_q      <= '0;
      glast_q   <= 1'b0;
      key_in_q  <= '0;
      v_in_q    <= '0;
      rc_in_q   <= '0;
      fips_in_q <= 1'b0;
      sts_q     <= CMD_STS_SUCCESS;
      for (int unsigned i = 0; i < NumApps; i++) begin
        valid_q[i] <= 1'b0;
        key_q[i]   <= '0;
        v_q[i]     <= '0;
        rc_q[i]    <= '0;
        fips_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (wb_req_i && wb_rdy_o) begin
        ccmd_q    <= wb_ccmd_i;
        id_q      <= wb_inst_id_i;
        glast_q   <= wb_glast_i;
        key_in_q  <= wb_key_i;
        v_in_q    <= wb_v_i;
        rc_in_q   <= wb_rc_i;
        fips_in_q <= wb_fips_i;
      end
      if (state_q == ST_WB) begin
        sts_q <= sts_d;
        for (int unsigned i = 0; i < NumApps; i++) begin
          if (we && (id_q == StateId'(i))) begin
            valid_q[i] <= !is_uni;
            key_q[i]   <= is_uni ? '0 : key_in_q;
            v_q[i]     <= is_uni ? '0 : v_in_q;
            rc_q[i]    <= is_uni ? '0 : rc_in_q;
            fips_q[i]  <= is_uni ? 1'b0 : fips_in_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_csrng_state_wb.sv
// Directed testbench for csrng_state_wb: write-back handshake latency,
// legality checks, GEN beat handling, read port behaviour, and disable clear.
module tb_csrng_state_wb;
  import csrng_pkg::*;

  logic           clk = 1'b0;
  logic           rst_i, enable_i, wb_req_i, wb_rdy_o, wb_glast_i, wb_fips_i;
  logic [2:0]     wb_ccmd_i;
  logic [3:0]     wb_inst_id_i, ack_inst_id_o, rd_inst_id_i;
  logic [255:0]   wb_key_i, rd_key_o;
  logic [127:0]   wb_v_i, rd_v_o;
  logic [31:0]    wb_rc_i, reseed_interval_i, rd_rc_o;
  logic           ack_o, ack_rdy_i, rd_valid_o, rd_fips_o;
  csrng_cmd_sts_e ack_sts_o;

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] K1 = {8{32'h1111_1111}};
  localparam logic [255:0] K2 = {8{32'h2222_2222}};
  localparam logic [255:0] K3 = {8{32'h3333_3333}};
  localparam logic [127:0] V1 = {4{32'hA1A1_A1A1}};
  localparam logic [127:0] VA = {4{32'h0000_000A}};
  localparam logic [127:0] VB = {4{32'h0000_000B}};
  localparam logic [127:0] VC = {4{32'h0000_000C}};

  always #5 clk = ~clk;

  csrng_state_wb #(
    .NumApps(3), .Cmd(3), .StateId(4), .BlkLen(128), .KeyLen(256), .CtrLen(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .wb_req_i(wb_req_i), .wb_rdy_o(wb_rdy_o), .wb_ccmd_i(wb_ccmd_i),
    .wb_inst_id_i(wb_inst_id_i), .wb_glast_i(wb_glast_i), .wb_key_i(wb_key_i),
    .wb_v_i(wb_v_i), .wb_rc_i(wb_rc_i), .wb_fips_i(wb_fips_i),
    .reseed_interval_i(reseed_interval_i),
    .ack_o(ack_o), .ack_rdy_i(ack_rdy_i), .ack_sts_o(ack_sts_o),
    .ack_inst_id_o(ack_inst_id_o), .rd_inst_id_i(rd_inst_id_i),
    .rd_valid_o(rd_valid_o), .rd_key_o(rd_key_o), .rd_v_o(rd_v_o),
    .rd_rc_o(rd_rc_o), .rd_fips_o(rd_fips_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the transfer edge (the WB cycle).
  task automatic do_cmd(input logic [2:0] c, input logic [3:0] id, input logic gl,
                        input logic [255:0] k, input logic [127:0] v,
                        input logic [31:0] rc, input logic f);
    int n = 0;
    @(negedge clk);
    wb_ccmd_i = c; wb_inst_id_i = id; wb_glast_i = gl;
    wb_key_i = k; wb_v_i = v; wb_rc_i = rc; wb_fips_i = f;
    wb_req_i = 1'b1;
    while (!wb_rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_rdy_before_transfer", wb_rdy_o, 1'b1);
    @(posedge clk);
    #1 wb_req_i = 1'b0;
  endtask

  // Wait (bounded) for an ack, check it, then consume it.
  task automatic expect_ack(input string tag, input csrng_cmd_sts_e sts, input logic [3:0] id);
    int n = 0;
    while (!ack_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_ack"}, ack_o, 1'b1);
    chk({tag, "_sts"}, ack_sts_o, sts);
    chk({tag, "_id"}, ack_inst_id_o, id);
    @(negedge clk) ack_rdy_i = 1'b1;
    @(posedge clk);
    #1 ack_rdy_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id);
    rd_inst_id_i = id;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; wb_req_i = 1'b0; ack_rdy_i = 1'b0;
    wb_ccmd_i = '0; wb_inst_id_i = '0; wb_glast_i = 1'b0; wb_key_i = '0;
    wb_v_i = '0; wb_rc_i = '0; wb_fips_i = 1'b0; reseed_interval_i = 32'd4;
    rd_inst_id_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_wb_rdy", wb_rdy_o, 1'b1);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_sts", ack_sts_o, CMD_STS_SUCCESS);
    chk("rst_ack_id", ack_inst_id_o, 4'd0);
    chk("rst_rd_valid", rd_valid_o, 1'b0);

    // INS id0: ack appears exactly in cycle N+2
    do_cmd(3'(INS), 4'd0, 1'b1, K1, V1, 32'd0, 1'b1);
    chk("ins_lat_n1_ack", ack_o, 1'b0);
    chk("ins_lat_n1_rdy", wb_rdy_o, 1'b0);
    @(posedge clk); #1;
    chk("ins_lat_n2_ack", ack_o, 1'b1);
    rd(4'd0);
    chk("ins_rd_valid", rd_valid_o, 1'b1);
    chk("ins_rd_key", rd_key_o, K1);
    chk("ins_rd_v", rd_v_o, V1);
    chk("ins_rd_fips", rd_fips_o, 1'b1);
    expect_ack("ins0", CMD_STS_SUCCESS, 4'd0);
    chk("post_ack_rdy", wb_rdy_o, 1'b1);

    // Second INS on id0 is a sequence error; key stays K1
    do_cmd(3'(INS), 4'd0, 1'b1, K2, VA, 32'd0, 1'b0);
    expect_ack("ins0_again", CMD_STS_INVALID_CMD_SEQ, 4'd0);
    rd(4'd0);
    chk("ins_again_key", rd_key_o, K1);

    // GEN with three beats; only the last one is acknowledged
    do_cmd(3'(GEN), 4'd0, 1'b0, K1, VA, 32'd1, 1'b1);
    @(posedge clk); #1;
    chk("gen_b1_noack", ack_o, 1'b0);
    chk("gen_b1_rdy", wb_rdy_o, 1'b1);
    do_cmd(3'(GEN), 4'd0, 1'b0, K1, VB, 32'd1, 1'b1);
    @(posedge clk); #1;
    chk("gen_b2_noack", ack_o, 1'b0);
    rd(4'd0);
    chk("gen_b2_v", rd_v_o, VB);
    do_cmd(3'(GEN), 4'd0, 1'b1, K1, VC, 32'd1, 1'b1);
    expect_ack("gen_last", CMD_STS_SUCCESS, 4'd0);
    rd(4'd0);
    chk("gen_rd_v", rd_v_o, VC);
    chk("gen_rd_rc", rd_rc_o, 32'd1);

    // Reseed interval limit: rc=5 is rejected, rc=4 (the boundary) is accepted
    do_cmd(3'(GEN), 4'd0, 1'b1, K2, VA, 32'd5, 1'b1);
    expect_ack("gen_rc5", CMD_STS_RESEED_CNT_EXCEEDED, 4'd0);
    rd(4'd0);
    chk("gen_rc5_rc_kept", rd_rc_o, 32'd1);
    chk("gen_rc5_key_kept", rd_key_o, K1);
    do_cmd(3'(GEN), 4'd0, 1'b1, K1, VB, 32'd4, 1'b1);
    expect_ack("gen_rc4", CMD_STS_SUCCESS, 4'd0);
    rd(4'd0);
    chk("gen_rc4_rc", rd_rc_o, 32'd4);

    // Out-of-range ids
    do_cmd(3'(INS), 4'd7, 1'b1, K2, VA, 32'd0, 1'b1);
    expect_ack("id7", CMD_STS_INVALID_ACMD, 4'd7);
    rd(4'd7);
    chk("rd7_valid", rd_valid_o, 1'b0);
    chk("rd7_key", rd_key_o, 256'd0);
    chk("rd7_v", rd_v_o, 128'd0);
    chk("rd7_rc", rd_rc_o, 32'd0);
    chk("rd7_fips", rd_fips_o, 1'b0);
    rd(4'd3);
    chk("rd3_valid", rd_valid_o, 1'b0);

    // RES on an uninstantiated entry, unknown opcode, UNI, then re-INS
    do_cmd(3'(RES), 4'd1, 1'b1, K2, VA, 32'd0, 1'b0);
    expect_ack("res_id1", CMD_STS_INVALID_CMD_SEQ, 4'd1);
    do_cmd(3'd7, 4'd0, 1'b1, K2, VA, 32'd0, 1'b0);
    expect_ack("bad_cmd", CMD_STS_INVALID_ACMD, 4'd0);
    do_cmd(3'(UNI), 4'd0, 1'b1, K2, VA, 32'd3, 1'b1);
    expect_ack("uni0", CMD_STS_SUCCESS, 4'd0);
    rd(4'd0);
    chk("uni_valid", rd_valid_o, 1'b0);
    chk("uni_key", rd_key_o, 256'd0);
    chk("uni_rc", rd_rc_o, 32'd0);
    do_cmd(3'(INS), 4'd0, 1'b1, K2, VA, 32'd0, 1'b0);
    expect_ack("reins0", CMD_STS_SUCCESS, 4'd0);
    rd(4'd0);
    chk("reins_key", rd_key_o, K2);

    // Ack backpressure with a new request pending, then disable mid-RSP
    do_cmd(3'(INS), 4'd2, 1'b1, K3, VC, 32'd0, 1'b1);
    wb_req_i = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ack", ack_o, 1'b1);
      chk("hold_sts", ack_sts_o, CMD_STS_SUCCESS);
      chk("hold_rdy", wb_rdy_o, 1'b0);
      @(posedge clk); #1;
    end
    rd(4'd2);
    chk("hold_rd_key2", rd_key_o, K3);
    @(negedge clk) enable_i = 1'b0;
    @(posedge clk); #1;
    chk("dis_ack", ack_o, 1'b0);
    chk("dis_rdy", wb_rdy_o, 1'b0);
    rd(4'd0);
    chk("dis_valid0", rd_valid_o, 1'b0);
    chk("dis_key0", rd_key_o, 256'd0);
    rd(4'd2);
    chk("dis_valid2", rd_valid_o, 1'b0);
    wb_req_i = 1'b0;
    @(negedge clk) enable_i = 1'b1;
    #1;
    chk("reen_rdy", wb_rdy_o, 1'b1);
    chk("reen_sts", ack_sts_o, CMD_STS_SUCCESS);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
